// File: rtl/dict_chip_initiator.sv
// Host-side initiator for the dictionary compression chip: issues one command per
// request, waits for and classifies the chip's response, returns a registered result.
module dict_chip_initiator #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [79:0]          req_data,
  input  logic [7:0]           req_code,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_status,
  output logic [7:0]           rsp_code,
  output logic [79:0]          rsp_data,
  output logic [1:0]           chip_command,
  output logic [79:0]          chip_data_in,
  output logic [7:0]           chip_compressed_in,
  input  logic [7:0]           chip_compressed_out,
  input  logic [79:0]          chip_decompressed_out,
  input  logic [1:0]           chip_response,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] ok_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] TIMEOUT_L = TIMEOUT_CYCLES[7:0];

  localparam logic [1:0] STATUS_OK       = 2'b00;
  localparam logic [1:0] STATUS_CHIP_ERR = 2'b01;
  localparam logic [1:0] STATUS_MISMATCH = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b11;

  logic [1:0] state;
  logic       op_reg;
  logic [7:0] timer;

  logic       cls_valid;
  logic [1:0] cls_status;
  logic [1:0] expected_rsp;

  // Response classification for the current WAIT cycle; an idle response only
  // classifies once this cycle would be the TIMEOUT_CYCLES-th silent one.
  always_comb begin
    cls_valid    = 1'b0;
    cls_status   = STATUS_OK;
    expected_rsp = op_reg ? 2'b10 : 2'b01;
    if (chip_response == 2'b11) begin
      cls_valid  = 1'b1;
      cls_status = STATUS_CHIP_ERR;
    end else if (chip_response == expected_rsp) begin
      cls_valid  = 1'b1;
      cls_status = STATUS_OK;
    end else if (chip_response != 2'b00) begin
      cls_valid  = 1'b1;
      cls_status = STATUS_MISMATCH;
    end else if (timer + 8'd1 == TIMEOUT_L) begin
      cls_valid  = 1'b1;
      cls_status = STATUS_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      op_reg             <= 1'b0;
      timer              <= 8'd0;
      req_ready          <= 1'b1;
      rsp_valid          <= 1'b0;
      rsp_status         <= 2'b00;
      rsp_code           <= 8'd0;
      rsp_data           <= 80'd0;
      chip_command       <= 2'b00;
      chip_data_in       <= 80'd0;
      chip_compressed_in <= 8'd0;
      busy               <= 1'b0;
      ok_count           <= '0;
      err_count          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_reg             <= req_op;
            chip_command       <= req_op ? 2'b10 : 2'b01;
            chip_data_in       <= req_data;
            chip_compressed_in <= req_code;
            req_ready          <= 1'b0;
            busy               <= 1'b1;
            state              <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          chip_command <= 2'b00;
          timer        <= 8'd0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cls_valid) begin
            rsp_valid  <= 1'b1;
            rsp_status <= cls_status;
            rsp_code   <= (cls_status == STATUS_OK && !op_reg) ? chip_compressed_out : 8'd0;
            rsp_data   <= (cls_status == STATUS_OK && op_reg) ? chip_decompressed_out : 80'd0;
            if (cls_status == STATUS_OK) begin
              if (ok_count != '1) ok_count <= ok_count + CNT_WIDTH'(1);
            end else begin
              if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
            end
            state <= ST_DONE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dict_chip_initiator.md
Name: dict_chip_initiator

Overview:
- Host-side command sequencer for the dictionary compression/decompression chip; it is the initiator end of the chip's command/response interface.
- Accepts one compress or decompress request at a time on a valid/ready port and drives the chip's command, data_in and compressed_in pins.
- Waits for a non-NOP chip response, classifies it, and returns code, data and status on a valid/ready result port.
- Keeps saturating success/error counters for verification and debug.

Parameters:
- TIMEOUT_CYCLES, 8: max WAIT cycles for a non-zero chip_response before the timeout status is reported; legal range 1..255.
- CNT_WIDTH, 16: width of ok_count and err_count.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  initiator can accept a request (high only in IDLE)
- req_op  in  1  0 = compress, 1 = decompress
- req_data  in  80  word to compress
- req_code  in  8  code to decompress
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_status  out  2  00 OK, 01 chip error (response 11), 10 mismatched response, 11 timeout
- rsp_code  out  8  captured chip_compressed_out (compress OK), else 0
- rsp_data  out  80  captured chip_decompressed_out (decompress OK), else 0
- chip_command  out  2  to chip command: 00 NOP, 01 compress, 10 decompress; 11 never driven
- chip_data_in  out  80  to chip data_in
- chip_compressed_in  out  8  to chip compressed_in
- chip_compressed_out  in  8  from chip
- chip_decompressed_out  in  80  from chip
- chip_response  in  2  from chip
- busy  out  1  high in any state other than IDLE
- ok_count  out  CNT_WIDTH  results returned with status 00, saturating
- err_count  out  CNT_WIDTH  results returned with status other than 00, saturating

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, except req_ready = 1. FSM = IDLE, timeout counter = 0.
- Reset asserted mid-operation aborts the transaction immediately. No result is produced, counters clear, and chip_command returns to NOP.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready = 1; chip_command = 00.
  - On req_valid && req_ready, latch the op, drive chip_command = 01 (op 0) or 10 (op 1), drive chip_data_in = req_data and chip_compressed_in = req_code, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - The chip samples the command at this cycle's closing edge.
  - At that edge, chip_command becomes 00; chip_data_in and chip_compressed_in hold their values. Go to WAIT with timer = 0.
- WAIT:
  - Each cycle, sample chip_response.
  - Compress op: 01 gives status 00 and captures rsp_code.
  - Decompress op: 10 gives status 00 and captures rsp_data.
  - 11 gives status 01.
  - The other non-zero value (10 for compress, 01 for decompress) gives status 10.
  - 00 increments the timer. When the timer reaches TIMEOUT_CYCLES, status is 11.
  - On any classification, load rsp_*, set rsp_valid = 1, update a counter, and go to DONE.
  - Nominal chip latency: chip_response is valid in the first WAIT cycle. Total request-accept to rsp_valid = 3 clock edges.
- DONE:
  - rsp_* are held stable while rsp_valid = 1 and rsp_ready = 0.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - req_ready rises the cycle after the result handshake. No overlapped transactions.
- Counters saturate at all-ones and never wrap.
- chip_command is never 11. Only one non-NOP command is issued per request.
- rsp_code and rsp_data are zeroed on a non-OK status.

Test Plan:
- Compress 0x0000_0000_0000_0000_ABCD on an empty chip -> chip_command 01 for one cycle; rsp_status 00, rsp_code 0x00, ok_count 1. Same word again -> rsp_code 0x00, ok_count 2.
- Compress A then B, then decompress code 0x01 -> rsp_data = B, status 00; rsp_valid held 5 cycles with rsp_ready low; outputs stable.
- Decompress code 0xF0 on a chip holding 2 entries -> chip returns 11; rsp_status 01, rsp_data 0, err_count 1.
- Model chip that never responds (response held 00), TIMEOUT_CYCLES = 8 -> rsp_status 11 exactly 8 WAIT cycles after ISSUE; err_count increments.
- Model chip returns 10 to a compress -> rsp_status 10.
- Assert reset during WAIT -> all outputs 0 except req_ready = 1 next cycle; no rsp_valid; next request completes normally.
